// File: rtl/adder_global_pkg.sv
// Environment-wide settings for the adder agent and its bench.
package adder_global_pkg;
  localparam bit ADDER_AGENT_ACTIVE = 1'b1;
  localparam int DELAY              = 1;
endpackage

// File: rtl/adder_sched_pkg.sv
// Shared sizes and types for the round-robin adder scheduler.
package adder_sched_pkg;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = $clog2(NUM_REQ);
  localparam int CNT_WIDTH  = 16;

  typedef logic [ID_WIDTH-1:0] req_id_t;

  typedef struct packed {
    logic                  cout;
    logic [DATA_WIDTH-1:0] sum;
    req_id_t               id;
  } adder_result_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} sched_state_e;
endpackage

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module adder_rr_arbiter #(
  parameter int NUM_REQ  = adder_sched_pkg::NUM_REQ,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic                enable,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  // Walk NUM_REQ slots starting at ptr, wrapping at NUM_REQ; first hit wins.
  always_comb begin : search
    logic                found;
    logic [ID_WIDTH:0]   pos;
    logic [ID_WIDTH-1:0] slot;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    slot      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + k[ID_WIDTH:0];
      if (pos >= (ID_WIDTH+1)'(NUM_REQ))
        pos = pos - (ID_WIDTH+1)'(NUM_REQ);
      slot = pos[ID_WIDTH-1:0];
      if (enable && !found && req[slot]) begin
        found       = 1'b1;
        grant[slot] = 1'b1;
        grant_idx   = slot;
      end
    end
  end

endmodule

// File: rtl/adder_req_scheduler.sv
// Shares one adder among NUM_REQ requesters with a single-entry result register.
module adder_req_scheduler #(
  parameter int NUM_REQ    = adder_sched_pkg::NUM_REQ,
  parameter int DATA_WIDTH = adder_sched_pkg::DATA_WIDTH,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int CNT_WIDTH  = adder_sched_pkg::CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_cin,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_sum,
  output logic                          resp_cout,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [CNT_WIDTH-1:0]          op_count
);
  import adder_sched_pkg::*;

  sched_state_e          state;
  logic [ID_WIDTH-1:0]   ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic                  can_accept;
  logic                  transfer;
  logic                  retire;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;
  logic                  cin_sel;
  logic [DATA_WIDTH:0]   full_sum;

  assign resp_valid = (state == FULL);
  assign can_accept = !resp_valid || resp_ready;
  assign retire     = resp_valid && resp_ready;
  assign transfer   = |grant;
  assign req_ready  = grant;

  adder_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arbiter (
    .req       (req_valid),
    .enable    (can_accept && !rst),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is one-hot, so an OR-of-masked-slices mux picks the winner's operands.
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel   = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_sel   = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        cin_sel = req_cin[i];
      end
    end
  end

  assign full_sum = {1'b0, a_sel} + {1'b0, b_sel} + {{DATA_WIDTH{1'b0}}, cin_sel};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      ptr       <= '0;
      resp_sum  <= '0;
      resp_cout <= 1'b0;
      resp_id   <= '0;
      op_count  <= '0;
    end else begin
      if (retire)
        op_count <= op_count + 1'b1;
      // A new grant reloads the register even while the old entry retires.
      if (transfer) begin
        state     <= FULL;
        resp_cout <= full_sum[DATA_WIDTH];
        resp_sum  <= full_sum[DATA_WIDTH-1:0];
        resp_id   <= grant_idx;
        ptr       <= (grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end else if (retire) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_adder_req_scheduler.sv
// Directed self-checking bench for adder_req_scheduler.
module tb_adder_req_scheduler;
  import adder_sched_pkg::*;
  import adder_global_pkg::*;

  logic                          clk;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]            req_cin;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [DATA_WIDTH-1:0]         resp_sum;
  logic                          resp_cout;
  logic [ID_WIDTH-1:0]           resp_id;
  logic [CNT_WIDTH-1:0]          op_count;

  int errors = 0;
  int checks = 0;

  adder_req_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .resp_id    (resp_id),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input int idx, input logic [DATA_WIDTH-1:0] a,
                               input logic [DATA_WIDTH-1:0] b, input logic cin);
    req_a[idx*DATA_WIDTH +: DATA_WIDTH] = a;
    req_b[idx*DATA_WIDTH +: DATA_WIDTH] = b;
    req_cin[idx]                        = cin;
    req_valid[idx]                      = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #(DELAY);
  endtask

  task automatic settle();
    #(DELAY);
  endtask

  task automatic checkResult(input string tag, input adder_result_t exp_r);
    checkOutput({tag, "_valid"}, 64'(resp_valid), 64'(1));
    checkOutput({tag, "_sum"},   64'(resp_sum),   64'(exp_r.sum));
    checkOutput({tag, "_cout"},  64'(resp_cout),  64'(exp_r.cout));
    checkOutput({tag, "_id"},    64'(resp_id),    64'(exp_r.id));
  endtask

  logic [DATA_WIDTH-1:0] rr_sum [4];
  adder_result_t         exp_r;

  initial begin
    rr_sum[0] = 32'h0000_0010;
    rr_sum[1] = 32'h0000_0022;
    rr_sum[2] = 32'h0000_0032;
    rr_sum[3] = 32'h0000_0044;

    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_cin    = '0;
    resp_ready = 1'b0;

    // Reset: ready suppressed even with requests present
    tick();
    req_valid = '1;
    settle();
    checkOutput("rst_ready", 64'(req_ready), 64'(0));
    tick();
    checkOutput("rst_valid", 64'(resp_valid), 64'(0));
    checkOutput("rst_sum",   64'(resp_sum),   64'(0));
    checkOutput("rst_cout",  64'(resp_cout),  64'(0));
    checkOutput("rst_id",    64'(resp_id),    64'(0));
    checkOutput("rst_count", 64'(op_count),   64'(0));
    rst       = 1'b0;
    req_valid = '0;

    // Single request from requester 2
    applyStimulus(2, 32'h5, 32'h7, 1'b0);
    settle();
    checkOutput("t1_ready", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = '0;
    exp_r = '{cout: 1'b0, sum: 32'h0000_000C, id: 2'd2};
    checkResult("t1", exp_r);
    checkOutput("t1_count_pre", 64'(op_count), 64'(0));
    resp_ready = 1'b1;
    tick();
    checkOutput("t1_retired", 64'(resp_valid), 64'(0));
    checkOutput("t1_count",   64'(op_count),   64'(1));

    // Carry out of the top bit; pointer is 3 so requester 1 is reached by wrap
    applyStimulus(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    settle();
    checkOutput("t2_ready", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = '0;
    exp_r = '{cout: 1'b1, sum: 32'h0000_0001, id: 2'd1};
    checkResult("t2", exp_r);
    tick();
    checkOutput("t2_count", 64'(op_count), 64'(2));

    // All requesters valid: strict rotation from 0, one result per cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus(i, 32'(32'h10 * (i + 1)), 32'(i), 1'(i % 2));
    resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      checkOutput($sformatf("t3_ready%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      checkOutput($sformatf("t3_id%0d", k),  64'(resp_id),  64'(k % 4));
      checkOutput($sformatf("t3_sum%0d", k), 64'(resp_sum), 64'(rr_sum[k % 4]));
    end
    req_valid = '0;
    tick();
    checkOutput("t3_count", 64'(op_count),   64'(8));
    checkOutput("t3_empty", 64'(resp_valid), 64'(0));

    // Backpressure holds the result and blocks grants
    resp_ready = 1'b0;
    applyStimulus(1, 32'h100, 32'h23, 1'b1);
    tick();
    req_valid = '0;
    applyStimulus(3, 32'h1000, 32'h0FFF, 1'b1);
    exp_r = '{cout: 1'b0, sum: 32'h0000_0124, id: 2'd1};
    for (int k = 0; k < 5; k++) begin
      settle();
      checkOutput($sformatf("t4_ready%0d", k), 64'(req_ready), 64'(0));
      checkResult($sformatf("t4_hold%0d", k), exp_r);
      tick();
    end
    resp_ready = 1'b1;
    settle();
    checkOutput("t4_ready_go", 64'(req_ready), 64'(4'b1000));
    tick();
    req_valid = '0;
    exp_r = '{cout: 1'b0, sum: 32'h0000_2000, id: 2'd3};
    checkResult("t4_reload", exp_r);
    checkOutput("t4_count", 64'(op_count), 64'(9));

    // Reset while a result for requester 1 is held
    applyStimulus(1, 32'h1, 32'h1, 1'b0);
    tick();
    req_valid  = '0;
    resp_ready = 1'b0;
    exp_r = '{cout: 1'b0, sum: 32'h0000_0002, id: 2'd1};
    checkResult("t5_held", exp_r);
    checkOutput("t5_count_pre", 64'(op_count), 64'(10));
    rst       = 1'b1;
    req_valid = '1;
    settle();
    checkOutput("t5_rst_ready", 64'(req_ready), 64'(0));
    tick();
    checkOutput("t5_valid", 64'(resp_valid), 64'(0));
    checkOutput("t5_count", 64'(op_count),   64'(0));
    rst       = 1'b0;
    req_valid = '0;
    applyStimulus(0, 32'hA, 32'h5, 1'b0);
    applyStimulus(2, 32'hB, 32'h5, 1'b0);
    resp_ready = 1'b1;
    settle();
    checkOutput("t5_ready", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    exp_r = '{cout: 1'b0, sum: 32'h0000_000F, id: 2'd0};
    checkResult("t5_first", exp_r);

    // Counter wrap after 65535 then one more retire
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 32'h1, 32'h2, 1'b0);
    for (int k = 0; k < 65535; k++)
      tick();
    req_valid = '0;
    tick();
    checkOutput("t6_full",  64'(op_count),   64'(16'hFFFF));
    checkOutput("t6_empty", 64'(resp_valid), 64'(0));
    applyStimulus(0, 32'h1, 32'h2, 1'b0);
    tick();
    req_valid = '0;
    tick();
    checkOutput("t6_wrap", 64'(op_count), 64'(16'h0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
